// File: rtl/act_lut_interp_pipe_if.sv
// Stream and ROM-port bundle for the pipelined tanh/sigmoid activation unit.
// master: the surrounding system (sample source, result sink, tanh ROM).
// slave: the activation unit itself.
interface act_lut_interp_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sat;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr_a;
  logic [ADDR_WIDTH-1:0] rom_addr_b;
  logic [DATA_WIDTH-1:0] rom_data_a;
  logic [DATA_WIDTH-1:0] rom_data_b;

  modport master (
    output in_valid, in_data, in_mode, out_ready, rom_data_a, rom_data_b,
    input  in_ready, out_valid, out_data, out_sat, rom_en, rom_addr_a, rom_addr_b
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready, rom_data_a, rom_data_b,
    output in_ready, out_valid, out_data, out_sat, rom_en, rom_addr_a, rom_addr_b
  );
endinterface

// File: rtl/act_lut_interp_pipe.sv
// Pipelined tanh/sigmoid unit: address/fraction calculation, synchronous ROM
// read of two adjacent tanh entries, linear interpolation, then symmetry,
// linear-region passthrough, saturation and the sigmoid remap.
// Stages: S1 (address) -> RD (ROM access) -> S2 (interpolate) -> S3 (output).
module act_lut_interp_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int LUT_MIN    = 1024,
  parameter int STEP_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  act_lut_interp_pipe_if.slave bus
);
  typedef enum logic [1:0] {REG_LIN = 2'd0, REG_LUT = 2'd1, REG_SAT = 2'd2} region_t;

  localparam int XMAX = LUT_MIN + ((DEPTH - 1) << STEP_SHIFT);
  localparam int DW1  = DATA_WIDTH + 1;
  localparam int PW   = DATA_WIDTH + STEP_SHIFT + 2;
  localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DW1-1:0] ONE_W    = DW1'(1 << FRAC_BITS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // S1 registers (the ROM addresses are part of this stage)
  logic                         s1_valid_reg, s1_sign_reg, s1_mode_reg;
  region_t                      s1_region_reg;
  logic [STEP_SHIFT-1:0]        s1_frac_reg;
  logic signed [DATA_WIDTH-1:0] s1_xeff_reg;
  logic [ADDR_WIDTH-1:0]        rom_addr_a_reg, rom_addr_b_reg;
  // RD registers: sideband waiting for the ROM read
  logic                         rd_valid_reg, rd_sign_reg, rd_mode_reg;
  region_t                      rd_region_reg;
  logic [STEP_SHIFT-1:0]        rd_frac_reg;
  logic signed [DATA_WIDTH-1:0] rd_xeff_reg;
  // S2 registers
  logic                         s2_valid_reg, s2_sign_reg, s2_mode_reg;
  region_t                      s2_region_reg;
  logic signed [DATA_WIDTH-1:0] s2_xeff_reg;
  logic [DATA_WIDTH-1:0]        s2_tmag_reg;
  // S3 output registers
  logic                         out_valid_reg, out_sat_reg;
  logic [DATA_WIDTH-1:0]        out_data_reg;

  logic stall;
  assign stall          = out_valid_reg & ~bus.out_ready;
  assign bus.in_ready   = ~stall;
  assign bus.rom_en     = ~stall;
  assign bus.rom_addr_a = rom_addr_a_reg;
  assign bus.rom_addr_b = rom_addr_b_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_sat    = out_sat_reg;

  logic signed [DATA_WIDTH-1:0] x_eff_next;
  logic                         sign_next;
  logic [DATA_WIDTH-1:0]        mag_next;
  logic [31:0]                  mag_ext, off_full, addr_full;
  region_t                      region_next;
  logic [ADDR_WIDTH-1:0]        addr_a_next, addr_b_next;
  logic [STEP_SHIFT-1:0]        frac_next;

  // S1 combinational: effective input, magnitude, region and LUT address/fraction
  always_comb begin
    x_eff_next = bus.in_mode ? ($signed(bus.in_data) >>> 1) : $signed(bus.in_data);
    sign_next  = x_eff_next[DATA_WIDTH-1];
    if (!sign_next)                  mag_next = x_eff_next;
    else if (x_eff_next == MOST_NEG) mag_next = MAG_MAX;
    else                             mag_next = -x_eff_next;
    mag_ext     = 32'(mag_next);
    off_full    = mag_ext - 32'(LUT_MIN);
    addr_full   = off_full >> STEP_SHIFT;
    region_next = REG_LUT;
    addr_a_next = '0;
    addr_b_next = '0;
    frac_next   = '0;
    if (mag_ext < 32'(LUT_MIN)) begin
      region_next = REG_LIN;
    end else if (mag_ext >= 32'(XMAX)) begin
      region_next = REG_SAT;
    end else begin
      addr_a_next = ADDR_WIDTH'(addr_full);
      addr_b_next = (addr_full >= 32'(DEPTH - 1)) ? LAST_ADDR : ADDR_WIDTH'(addr_full + 32'd1);
      frac_next   = off_full[STEP_SHIFT-1:0];
    end
  end

  // S1 register: sample fields load only on accept so idle cycles leave the ROM address alone
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_mode_reg    <= 1'b0;
      s1_region_reg  <= REG_LIN;
      s1_frac_reg    <= '0;
      s1_xeff_reg    <= '0;
      rom_addr_a_reg <= '0;
      rom_addr_b_reg <= '0;
    end else if (!stall) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_reg    <= sign_next;
        s1_mode_reg    <= bus.in_mode;
        s1_region_reg  <= region_next;
        s1_frac_reg    <= frac_next;
        s1_xeff_reg    <= x_eff_next;
        rom_addr_a_reg <= addr_a_next;
        rom_addr_b_reg <= addr_b_next;
      end
    end
  end

  // RD register: carry sideband alongside the ROM read so it meets the ROM data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg  <= 1'b0;
      rd_sign_reg   <= 1'b0;
      rd_mode_reg   <= 1'b0;
      rd_region_reg <= REG_LIN;
      rd_frac_reg   <= '0;
      rd_xeff_reg   <= '0;
    end else if (!stall) begin
      rd_valid_reg  <= s1_valid_reg;
      rd_sign_reg   <= s1_sign_reg;
      rd_mode_reg   <= s1_mode_reg;
      rd_region_reg <= s1_region_reg;
      rd_frac_reg   <= s1_frac_reg;
      rd_xeff_reg   <= s1_xeff_reg;
    end
  end

  logic signed [DW1-1:0] diff;
  logic signed [PW-1:0]  prod;
  logic [DATA_WIDTH-1:0] t_mag_next;

  // S2 combinational: a + floor((b - a) * frac / 2**STEP_SHIFT); the arithmetic shift floors
  always_comb begin
    diff       = $signed({1'b0, bus.rom_data_b}) - $signed({1'b0, bus.rom_data_a});
    prod       = PW'(diff) * PW'($signed({1'b0, rd_frac_reg}));
    t_mag_next = DATA_WIDTH'(PW'($signed({1'b0, bus.rom_data_a})) + (prod >>> STEP_SHIFT));
  end

  // S2 register: interpolated magnitude plus sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_sign_reg   <= 1'b0;
      s2_mode_reg   <= 1'b0;
      s2_region_reg <= REG_LIN;
      s2_xeff_reg   <= '0;
      s2_tmag_reg   <= '0;
    end else if (!stall) begin
      s2_valid_reg  <= rd_valid_reg;
      s2_sign_reg   <= rd_sign_reg;
      s2_mode_reg   <= rd_mode_reg;
      s2_region_reg <= rd_region_reg;
      s2_xeff_reg   <= rd_xeff_reg;
      s2_tmag_reg   <= t_mag_next;
    end
  end

  logic signed [DW1-1:0] t_w, sig_w;
  logic [DATA_WIDTH-1:0] out_data_next;

  // S3 combinational: odd symmetry / passthrough / saturation, then optional sigmoid remap
  always_comb begin
    case (s2_region_reg)
      REG_LIN: t_w = DW1'(s2_xeff_reg);
      REG_SAT: t_w = s2_sign_reg ? -ONE_W : ONE_W;
      default: t_w = s2_sign_reg ? -$signed({1'b0, s2_tmag_reg}) : $signed({1'b0, s2_tmag_reg});
    endcase
    sig_w         = (ONE_W + t_w) >>> 1;
    out_data_next = s2_mode_reg ? DATA_WIDTH'(sig_w) : DATA_WIDTH'(t_w);
  end

  // S3 register: result holds while stalled; data only reloads when a sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_data_reg <= out_data_next;
        out_sat_reg  <= (s2_region_reg == REG_SAT);
      end
    end
  end
endmodule

// File: tb/tb_act_lut_interp_pipe.sv
// Bench for act_lut_interp_pipe: directed samples, a behavioural ROM, and a
// scoreboard fed by an arithmetic model of the activation rules.
module tb_act_lut_interp_pipe;
  localparam int DW = 16, AW = 10, DEPTH = 1024, LUT_MIN = 1024, STEP = 4, ONE = 4096;
  localparam int XMAX = LUT_MIN + ((DEPTH - 1) << STEP);

  typedef struct {
    int data;
    bit sat;
    bit lit_en;
    int lit;
    bit lit_sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   rom [DEPTH];
  exp_t sbq [$];
  int   n_cmp = 0, n_err = 0, hs_count = 0;
  bit   cur_lit_en = 0, cur_lit_sat = 0;
  int   cur_lit = 0;

  act_lut_interp_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  act_lut_interp_pipe #(
    .DATA_WIDTH(DW), .FRAC_BITS(12), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .LUT_MIN(LUT_MIN), .STEP_SHIFT(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // synchronous tanh ROM, holds its output while rom_en is low
  always @(posedge clk) begin
    if (bus.rom_en) begin
      bus.rom_data_a <= 16'(rom[bus.rom_addr_a]);
      bus.rom_data_b <= 16'(rom[bus.rom_addr_b]);
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // floor division by a positive power of two, written out explicitly
  function automatic int floor_div(input int p, input int d);
    int q;
    q = p / d;
    if ((p % d) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  // activation result straight from the rules: tanh by table interpolation, sigmoid(x) = (1 + tanh(x/2)) / 2
  function automatic void model(input int x, input bit mode, output int d, output bit s);
    int xe, mag, off, idx, fr, a, b, t;
    xe  = mode ? floor_div(x, 2) : x;
    mag = (xe < 0) ? -xe : xe;
    if (mag > 32767) mag = 32767;
    s = 1'b0;
    if (mag < LUT_MIN) begin
      t = xe;
    end else if (mag >= XMAX) begin
      t = (xe < 0) ? -ONE : ONE;
      s = 1'b1;
    end else begin
      off = mag - LUT_MIN;
      idx = off / (1 << STEP);
      fr  = off % (1 << STEP);
      a   = rom[idx];
      b   = rom[(idx + 1 > DEPTH - 1) ? DEPTH - 1 : idx + 1];
      t   = a + floor_div((b - a) * fr, 1 << STEP);
      if (xe < 0) t = -t;
    end
    d = mode ? floor_div(ONE + t, 2) : t;
  endfunction

  // compare process: accepts feed the scoreboard, handshakes are checked against it
  initial begin
    exp_t e;
    bit   prev_stall = 0, prev_sat = 0;
    int   prev_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(bus.out_valid), 1);
          check("hold_data", int'($signed(bus.out_data)), prev_data);
          check("hold_sat", int'(bus.out_sat), int'(prev_sat));
        end
        check("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
        check("rom_en", int'(bus.rom_en), int'(!(bus.out_valid && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
          hs_count++;
          if (sbq.size() == 0) begin
            check("unexpected_output", int'($signed(bus.out_data)), 99999);
          end else begin
            e = sbq.pop_front();
            check("out_data", int'($signed(bus.out_data)), e.data);
            check("out_sat", int'(bus.out_sat), int'(e.sat));
            if (e.lit_en) begin
              check("lit_data", int'($signed(bus.out_data)), e.lit);
              check("lit_sat", int'(bus.out_sat), int'(e.lit_sat));
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          model(int'($signed(bus.in_data)), bus.in_mode, e.data, e.sat);
          e.lit_en  = cur_lit_en;
          e.lit     = cur_lit;
          e.lit_sat = cur_lit_sat;
          sbq.push_back(e);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = int'($signed(bus.out_data));
        prev_sat   = bus.out_sat;
      end
    end
  end

  // present one sample; returns #1 after the accepting edge
  task automatic send(input int x, input bit mode, input bit lit_en, input int lit, input bit lit_sat);
    int w;
    cur_lit_en   = lit_en;
    cur_lit      = lit;
    cur_lit_sat  = lit_sat;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(x);
    bus.in_mode  = mode;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sbq.size() != 0 || bus.out_valid) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("drain_timeout", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // isolated sample: optional address check, then latency must be exactly 3 edges
  task automatic send_lat(input int x, input bit mode, input int lit, input bit lit_sat,
                          input bit chk_addr, input int ea, input int eb);
    int lat;
    wait_drain();
    send(x, mode, 1'b1, lit, lit_sat);
    if (chk_addr) begin
      check("rom_addr_a", int'(bus.rom_addr_a), ea);
      check("rom_addr_b", int'(bus.rom_addr_b), eb);
    end
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d outputs, required completion", hs_count);
    $fatal(1, "watchdog");
  end

  initial begin
    int  d, base;
    bit  s;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) rom[i] = 1003 + 3 * i + (i % 5) * 4;
    rom[0] = 1003;
    rom[1] = 1018;
    rom[2] = 1010;

    // model pins against hand-computed values
    model(1032, 1'b0, d, s);  check("model_1032", d, 1010);
    model(-1032, 1'b0, d, s); check("model_m1032", d, -1010);
    model(1047, 1'b0, d, s);  check("model_1047_floor", d, 1014);
    model(20480, 1'b1, d, s); check("model_sig_20480", d, 3415);
    model(-1, 1'b1, d, s);    check("model_sig_m1", d, 2047);

    // reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    repeat (3) begin
      @(negedge clk);
      check("idle_addr_a", int'(bus.rom_addr_a), 0);
      check("idle_addr_b", int'(bus.rom_addr_b), 0);
      check("idle_out_valid", int'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;

    // tanh linear and saturation
    send_lat(512, 1'b0, 512, 1'b0, 1'b1, 0, 0);
    send_lat(-20480, 1'b0, -4096, 1'b1, 1'b0, 0, 0);
    // tanh interpolation, floor rounding and odd symmetry
    send_lat(1047, 1'b0, 1014, 1'b0, 1'b1, 1, 2);
    send_lat(1032, 1'b0, 1010, 1'b0, 1'b1, 0, 1);
    send_lat(-1032, 1'b0, -1010, 1'b0, 1'b1, 0, 1);
    // region boundaries
    send_lat(1023, 1'b0, 1023, 1'b0, 1'b0, 0, 0);
    send_lat(1024, 1'b0, 1003, 1'b0, 1'b1, 0, 1);
    send_lat(-1024, 1'b0, -1003, 1'b0, 1'b0, 0, 0);
    send_lat(XMAX - 1, 1'b0, 4083, 1'b0, 1'b1, DEPTH - 2, DEPTH - 1);
    send_lat(XMAX, 1'b0, 4096, 1'b1, 1'b1, 0, 0);
    send_lat(-32768, 1'b0, -4096, 1'b1, 1'b0, 0, 0);
    // sigmoid
    send_lat(0, 1'b1, 2048, 1'b0, 1'b0, 0, 0);
    send_lat(20480, 1'b1, 3415, 1'b0, 1'b1, 576, 577);
    send_lat(-1, 1'b1, 2047, 1'b0, 1'b0, 0, 0);
    send_lat(-1000, 1'b1, 1798, 1'b0, 1'b0, 0, 0);
    wait_drain();
    send(32767, 1'b1, 1'b0, 0, 1'b0);
    send(-32768, 1'b1, 1'b0, 0, 1'b0);
    send(1500, 1'b0, 1'b0, 0, 1'b0);
    wait_drain();

    // backpressure: 4 back-to-back samples, 5 stalled cycles, then a 4-cycle burst
    fork
      begin
        send(1100, 1'b0, 1'b0, 0, 1'b0);
        send(-2000, 1'b0, 1'b0, 0, 1'b0);
        send(3000, 1'b1, 1'b0, 0, 1'b0);
        send(-17000, 1'b0, 1'b0, 0, 1'b0);
      end
      begin
        int w2;
        w2 = 0;
        do begin
          @(posedge clk);
          #1;
          w2++;
        end while (!bus.out_valid && w2 < 50);
        check("bp_first_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", int'(bus.in_ready), 0);
          check("bp_rom_en", int'(bus.rom_en), 0);
          check("bp_out_valid", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        base = hs_count;
        repeat (4) @(negedge clk);
        #1;
        check("bp_burst", hs_count - base, 4);
      end
    join
    wait_drain();

    // reset mid-stream flushes in-flight samples
    send(700, 1'b0, 1'b0, 0, 1'b0);
    send(-1500, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_addr_a", int'(bus.rom_addr_a), 0);
    base = hs_count;
    repeat (8) @(negedge clk);
    #1;
    check("flush_no_output", hs_count - base, 0);
    @(posedge clk);
    #1;
    send_lat(-700, 1'b0, -700, 1'b0, 1'b0, 0, 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
